vga_scan_out: RTL and testbench

// Upstream/downstream bracket around drawer: generates 640x480@60 VGA timing from the
// 25.2 MHz pixel clock and hands drawer the half-resolution (320x240) scan coordinates
// x/y plus the per-frame vsync tick. Captures drawer's RGB565 pixel_data a fixed

---
 rtl/vga_scan_out.sv | 131 +++++++++++++
 tb/tb_vga_scan_out.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// VGA scan-out bracket: 640x480@60 timing, half-resolution scan coordinates for the
// drawer, and registered RGB565 pins with syncs delayed to match drawer latency.
module vga_scan_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [8:0]  x,
  output logic [8:0]  y,
  output logic        active,
  output logic        vsync_tick,
  input  logic [15:0] pixel_data,
  output logic [4:0]  vga_r,
  output logic [5:0]  vga_g,
  output logic [4:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // The counters hold the pixel about to be presented: every decoded output is
  // registered from them, so x/y/active/syncs all show the same pixel in one cycle.
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  logic [8:0] x_q, y_q;
  logic       active_q, active_d;
  logic       tick_q, tick_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;

  // Delay line entries are {active, hs_raw, vs_raw}.
  logic [2:0] dly_q [PIPE_DLY];

  logic [4:0] r_q;
  logic [5:0] g_q;
  logic [4:0] b_q;
  logic       pin_hs_q, pin_vs_q, pin_blank_q;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    active_d = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs_d     = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs_d     = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    tick_d   = (h_cnt_q == '0) && (v_cnt_q == V_VIS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      tick_q   <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      x_q      <= h_cnt_q[9:1];
      y_q      <= v_cnt_q[9:1];
      active_q <= active_d;
      tick_q   <= tick_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  // No handshake: pixel_data is taken every clock, PIPE_DLY clocks after its x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= 3'b011;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      pin_hs_q    <= 1'b1;
      pin_vs_q    <= 1'b1;
      pin_blank_q <= 1'b0;
    end else begin
      dly_q[0] <= {active_q, hs_q, vs_q};
      for (int i = 1; i < PIPE_DLY; i++) dly_q[i] <= dly_q[i-1];
      pin_blank_q <= dly_q[PIPE_DLY-1][2];
      pin_hs_q    <= dly_q[PIPE_DLY-1][1];
      pin_vs_q    <= dly_q[PIPE_DLY-1][0];
      r_q <= dly_q[PIPE_DLY-1][2] ? pixel_data[15:11] : '0;
      g_q <= dly_q[PIPE_DLY-1][2] ? pixel_data[10:5]  : '0;
      b_q <= dly_q[PIPE_DLY-1][2] ? pixel_data[4:0]   : '0;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign vsync_tick  = tick_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = pin_hs_q;
  assign vga_vs      = pin_vs_q;
  assign vga_blank_n = pin_blank_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: a full-size instance and a scaled-timing instance share
// clock, reset and pixel_data; both are checked every clock against an arithmetic model.
module tb_vga_scan_out;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pixel_data = 16'h0;

  initial forever #5 clk = ~clk;

  // Scaled timing for whole-frame checks within a short run.
  localparam int SHA = 48, SHF = 6, SHS = 10, SHB = 8;
  localparam int SVA = 24, SVF = 3, SVS = 2, SVB = 4;
  localparam int S_FRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);
  localparam int LAT = 3;

  logic [8:0] x_d, y_d, x_s, y_s;
  logic       act_d, tick_d, hs_d, vs_d, bl_d;
  logic       act_s, tick_s, hs_s, vs_s, bl_s;
  logic [4:0] r_d, b_d, r_s, b_s;
  logic [5:0] g_d, g_s;

  vga_scan_out dut_d (
    .clk(clk), .rst_n(rst_n), .x(x_d), .y(y_d), .active(act_d), .vsync_tick(tick_d),
    .pixel_data(pixel_data), .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
    .vga_hs(hs_d), .vga_vs(vs_d), .vga_blank_n(bl_d)
  );

  vga_scan_out #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .PIPE_DLY(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .x(x_s), .y(y_s), .active(act_s), .vsync_tick(tick_s),
    .pixel_data(pixel_data), .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bl_s)
  );

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic       active;
    logic       tick;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic       hs;
    logic       vs;
    logic       blank;
  } obs_t;

  typedef struct {
    int          k;
    logic [8:0]  x;
    logic [8:0]  y;
    logic        active;
    logic        hs;
    logic        blank;
    logic [15:0] rgb;
  } vec_t;

  vec_t tbl[12];
  int   ti = 0;

  int checks = 0, failures = 0;
  int k = 0;      // rising edges since reset release
  int mode = 0;   // 0 drawer pattern, 1 random, 2 all ones
  int n_vis_s = 0, n_tick_s = 0, n_vis_d = 0;
  bit frame_done = 0, line_done = 0;

  // ---------------- reference model ----------------
  // Outputs after edge kk show pixel kk-1; pins show pixel kk-1-LAT.
  function automatic obs_t model(input int kk, input int ha, input int hfp, input int hsw,
                                 input int hbp, input int va, input int vfp, input int vsw,
                                 input int vbp, input logic [15:0] pd);
    obs_t m;
    int ht, vt, n, h, v;
    bit vis;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    m = '0;
    m.hs = 1'b1;
    m.vs = 1'b1;
    if (kk >= 1) begin
      n = kk - 1;
      h = n % ht;
      v = (n / ht) % vt;
      m.x = 9'(h / 2);
      m.y = 9'(v / 2);
      m.active = (h < ha) && (v < va);
      m.tick = (h == 0) && (v == va);
    end
    if (kk >= LAT + 1) begin
      n = kk - 1 - LAT;
      h = n % ht;
      v = (n / ht) % vt;
      vis = (h < ha) && (v < va);
      m.blank = vis;
      m.hs = !((h >= ha + hfp) && (h < ha + hfp + hsw));
      m.vs = !((v >= va + vfp) && (v < va + vfp + vsw));
      if (vis) begin
        m.r = pd[15:11];
        m.g = pd[10:5];
        m.b = pd[4:0];
      end
    end
    return m;
  endfunction

  // Drawer output for full-size pixel n: {x[4:0], y[5:0], x[4:0]}.
  function automatic logic [15:0] pattern(input int n);
    logic [8:0] xx, yy;
    xx = 9'((n % 800) / 2);
    yy = 9'(((n / 800) % 525) / 2);
    return {xx[4:0], yy[5:0], xx[4:0]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, exp);
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_all(input logic [15:0] pd);
    cmp("dflt", {x_d, y_d, act_d, tick_d, r_d, g_d, b_d, hs_d, vs_d, bl_d},
        model(k, 640, 16, 96, 48, 480, 10, 2, 33, pd));
    cmp("small", {x_s, y_s, act_s, tick_s, r_s, g_s, b_s, hs_s, vs_s, bl_s},
        model(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, pd));
  endtask

  // ---------------- driver ----------------
  task automatic step();
    logic [15:0] sampled;
    logic [36:0] got_v, exp_v;
    @(posedge clk);
    if (rst_n) k++;
    sampled = pixel_data;
    #1;
    check_all(sampled);
    if (ti < 12 && k == tbl[ti].k) begin
      got_v = {x_d, y_d, act_d, hs_d, bl_d, r_d, g_d, b_d, 1'b0};
      exp_v = {tbl[ti].x, tbl[ti].y, tbl[ti].active, tbl[ti].hs, tbl[ti].blank, tbl[ti].rgb, 1'b0};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL vec%0d k=%0d got=%h exp=%h", ti, k, got_v, exp_v);
      end
      ti++;
    end
    if (!frame_done) begin
      if (k >= LAT + 1 && k < LAT + 1 + S_FRAME) n_vis_s += int'(bl_s);
      if (k >= 1 && k < 1 + S_FRAME) n_tick_s += int'(tick_s);
      if (k == LAT + 1 + S_FRAME) begin
        cmp_int("small_frame_visible", n_vis_s, SHA * SVA);
        cmp_int("small_frame_ticks", n_tick_s, 1);
        frame_done = 1;
      end
    end
    if (!line_done) begin
      if (k >= LAT + 1 && k < LAT + 1 + 800) n_vis_d += int'(bl_d);
      if (k == LAT + 1 + 800) begin
        cmp_int("dflt_line_visible", n_vis_d, 640);
        line_done = 1;
      end
    end
    case (mode)
      0:       pixel_data = (k >= LAT) ? pattern(k - LAT) : 16'h0;
      1:       pixel_data = 16'($urandom);
      default: pixel_data = 16'hFFFF;
    endcase
  endtask

  // ---------------- test ----------------
  initial begin
    //        k     x    y    act hs blank rgb
    tbl[0]  = '{1,    9'd0,   9'd0, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[1]  = '{4,    9'd1,   9'd0, 1'b1, 1'b1, 1'b1, 16'h0000};
    tbl[2]  = '{641,  9'd320, 9'd0, 1'b0, 1'b1, 1'b1, 16'hF01E};
    tbl[3]  = '{644,  9'd321, 9'd0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[4]  = '{659,  9'd329, 9'd0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[5]  = '{660,  9'd329, 9'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[6]  = '{755,  9'd377, 9'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[7]  = '{756,  9'd377, 9'd0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[8]  = '{800,  9'd399, 9'd0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[9]  = '{801,  9'd0,   9'd0, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[10] = '{2504, 9'd51,  9'd1, 1'b1, 1'b1, 1'b1, 16'h9032};
    tbl[11] = '{2505, 9'd52,  9'd1, 1'b1, 1'b1, 1'b1, 16'h9032};

    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;

    mode = 0;
    repeat (3000) step();
    mode = 1;
    repeat (4800) step();
    mode = 2;
    repeat (1000) step();

    // Mid-frame reset asserted between clock edges: pins must drop at once.
    #2 rst_n = 1'b0;
    k = 0;
    #1 check_all(pixel_data);
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;
    mode = 1;
    repeat (3000) step();

    cmp_int("table_entries_seen", ti, 12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
